// File: rtl/bcd_timer_pkg.sv
// Shared definitions for the BCD countdown timer: FSM states, BCD constants, digit clamp.
package bcd_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  // Non-decimal nibbles saturate to 9 so the counter always holds legal BCD.
  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_countdown_timer_if.sv
// Control/status bundle between the timer and its driver (panel or tick source).
interface bcd_countdown_timer_if #(
  parameter int unsigned DIGITS = 2
);
  localparam int unsigned W = 4 * DIGITS;

  logic         ld;
  logic [W-1:0] din;
  logic         start;
  logic         en;
  logic [W-1:0] q;
  logic         bo;
  logic         busy;
  logic         zero;

  modport master (output ld, din, start, en, input q, bo, busy, zero);
  modport slave  (input ld, din, start, en, output q, bo, busy, zero);
endinterface

// File: rtl/decade_down_digit.sv
// One BCD decade of the down-counter; borrows ripple to the next digit via bo_out.
module decade_down_digit
  import bcd_timer_pkg::*;
(
  input  logic       clk,
  input  logic       mr,
  input  logic       ld,
  input  logic [3:0] d,
  input  logic       dec_in,
  output logic [3:0] q,
  output logic       bo_out
);

  logic [3:0] q_q;

  // Reset, clamped load, or decrement with 0 -> 9 wrap.
  always_ff @(posedge clk) begin
    if (mr) begin
      q_q <= BCD_ZERO;
    end else if (ld) begin
      q_q <= clamp_digit(d);
    end else if (dec_in) begin
      q_q <= (q_q == BCD_ZERO) ? BCD_MAX : q_q - 4'd1;
    end
  end

  assign q      = q_q;
  assign bo_out = dec_in && (q_q == BCD_ZERO);

endmodule

// File: rtl/bcd_countdown_timer.sv
// Loadable multi-digit BCD countdown timer with IDLE/RUN/DONE control and a terminal pulse.
module bcd_countdown_timer
  import bcd_timer_pkg::*;
#(
  parameter int unsigned DIGITS      = 2,
  parameter int unsigned AUTO_RELOAD = 0
) (
  input  logic                  clk,
  input  logic                  mr,
  bcd_countdown_timer_if.slave  bus
);

  localparam int unsigned W       = 4 * DIGITS;
  localparam bit          AUTO_EN = (AUTO_RELOAD != 0);

  state_e       state_q;
  logic         bo_q;
  logic [W-1:0] reload_q;
  logic [W-1:0] din_clamped;
  logic [W-1:0] q_w;
  logic [W-1:0] dig_d;
  logic         dig_ld;
  logic         zero_w;
  logic         one_w;
  logic         reload_run;
  logic [DIGITS:0] chain;
  logic         borrow_unused;

  assign zero_w     = (q_w == '0);
  assign one_w      = (q_w == W'(1));
  assign reload_run = AUTO_EN && (reload_q != '0);

  // Digits are reloaded on an external load and on leaving DONE (reload value or zero).
  assign dig_ld   = bus.ld || (state_q == ST_DONE);
  assign dig_d    = bus.ld ? bus.din : (reload_run ? reload_q : '0);
  assign chain[0] = (state_q == ST_RUN) && bus.en;
  assign borrow_unused = chain[DIGITS];

  // Per-digit clamp for the reload register and the digit cascade.
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    assign din_clamped[4*i +: 4] = clamp_digit(bus.din[4*i +: 4]);

    decade_down_digit u_dig (
      .clk    (clk),
      .mr     (mr),
      .ld     (dig_ld),
      .d      (dig_d[4*i +: 4]),
      .dec_in (chain[i]),
      .q      (q_w[4*i +: 4]),
      .bo_out (chain[i+1])
    );
  end

  // Reload register captures the clamped preset on every load.
  always_ff @(posedge clk) begin
    if (mr) begin
      reload_q <= '0;
    end else if (bus.ld) begin
      reload_q <= din_clamped;
    end
  end

  // Control FSM; bo is set exactly when DONE is entered, so it spans only the DONE cycle.
  always_ff @(posedge clk) begin
    if (mr || bus.ld) begin
      state_q <= ST_IDLE;
      bo_q    <= 1'b0;
    end else begin
      bo_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            if (zero_w) begin
              state_q <= ST_DONE;
              bo_q    <= 1'b1;
            end else begin
              state_q <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (bus.en && one_w) begin
            state_q <= ST_DONE;
            bo_q    <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= reload_run ? ST_RUN : ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.q    = q_w;
  assign bus.bo   = bo_q;
  assign bus.busy = (state_q == ST_RUN);
  assign bus.zero = zero_w;

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
- Loadable, multi-digit BCD decade down-counter with a run/done state machine and a borrow/terminal pulse.
- Counterpart of the team's decade up-counter (mr/en/q/co): counts down instead of up and issues a terminal pulse (bo) at zero instead of a carry at 9.
- Sits after a front-panel or tick source as a preset countdown timer; q feeds the existing BCD display path.

Parameters:
- DIGITS, 2, number of cascaded BCD digits; q width is 4*DIGITS.
- AUTO_RELOAD, 0, 1 means reload the last loaded value and keep running after reaching zero; 0 means stop in IDLE.

Ports:
- clk  input  1  system clock; everything updates on the rising edge.
- mr  input  1  master reset; synchronous, active-high; highest priority.
- ld  input  1  load strobe; copies din into q and into the reload register.
- din  input  4*DIGITS  preset value in BCD, least-significant digit in [3:0].
- start  input  1  begin countdown; honoured only in IDLE.
- en  input  1  count enable; one decrement per clock while in RUN.
- q  output  4*DIGITS  current BCD count.
- bo  output  1  registered terminal pulse, one clock wide.
- busy  output  1  high while state is RUN; decoded from the state register.
- zero  output  1  high when q is all zeros; combinational from q.

Behaviour:
- Reset (mr=1 at an edge): q=0, reload register=0, state=IDLE, bo=0. So busy=0 and zero=1. Reset overrides ld, start and en, and may be asserted mid-RUN.
- Priority at each edge: mr, then ld, then state-machine action.
- Load (ld=1, no mr):
  - Each din digit greater than 9 is clamped to 9; the result goes to both q and the reload register.
  - State is forced to IDLE and bo=0, even if a countdown is running.
- States, encoded in 2 bits: IDLE, RUN, DONE.
- IDLE:
  - start=1 and q≠0: go to RUN, q unchanged.
  - start=1 and q=0: go to DONE, which produces a bo pulse.
  - Otherwise hold.
- RUN:
  - en=0: hold q and state.
  - en=1: decrement q by 1 in BCD. The digit-0 digit decrements; any digit at 0 wraps to 9 and borrows from the next digit.
  - If q=1 (00..01) and en=1: q becomes 0 and state goes to DONE.
  - start is ignored in RUN.
- DONE:
  - Lasts exactly one clock; bo=1 only while state=DONE, so the pulse is registered.
  - Next state: if AUTO_RELOAD=1 and reload≠0, q←reload and go to RUN. Otherwise go to IDLE with q=0.
  - start and en are ignored in DONE.
- Latency:
  - start sampled at edge k puts the block in RUN after k; the first decrement happens at edge k+1 if en=1.
  - Preset N with en held high: bo is high in the cycle following edge k+N.
- Wrap-around: q never wraps below 0 because the count stops at 0. Digit wrap from 0 to 9 happens only when a borrow occurs.
- bo and busy are never high together.

Decomposition:
- Shared package (bcd_timer_pkg) holds:
  - state localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - BCD_MAX=4'd9 and BCD_ZERO=4'd0.
- Sub-module decade_down_digit (one instance per digit, generated DIGITS times):
  - Ports: clk, mr, ld, d[3:0], dec_in, q[3:0], bo_out.
  - bo_out = dec_in && q==0.
  - Clamps d on load; on dec_in, decrements q, wrapping 0 to 9.
  - bo_out of digit i drives dec_in of digit i+1.
  - The top level owns the FSM, the reload register, the zero detect and bo.

Test Plan:
- mr=1 for 2 clocks, then 0: q=8'h00, zero=1, busy=0, bo=0. Repeat with mr asserted mid-RUN: same values at the next edge.
- ld with din=8'h03, start, en=1 held: q steps 03→02→01→00, busy high 3 cycles, bo=1 for exactly one cycle after q reaches 00, then IDLE.
- ld with din=8'h10, start, en=1: q 10→09→08; the borrow crosses digits correctly. ld with din=8'hFA loads 8'h99 (clamp).
- en toggling 1,0,0,1 in RUN from 8'h05: q 04, 04, 04, 03. start pulsed during RUN: no effect.
- AUTO_RELOAD=1, din=8'h02, start, en=1: pattern 02,01,00(bo=1),02,01,00(bo=1) repeats. ld=1 mid-run forces IDLE with the new value.
- start with q=00 in IDLE: one-cycle bo pulse, busy stays 0, then IDLE.
